// File: rtl/transceiver.sv
// One square of a systolic chess attack board. Each cycle the cell emits the
// attacks of the piece it holds, forwards sliding rays through itself when
// empty, and latches pseudo-legal moves for the engine's colour.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   engineColor         side to move (1=white, 0=black)
//   pieceReg            {color, piece[4:0]} (rook, bishop, king, pawn, knight)
//   posReg              this square index 0..63
//   <ray>_in/_out       {color, attack[3:0], srcPos[5:0]} per ray neighbour
//   <hop>_in/_out       {color, knightFlag, srcPos[5:0]} per knight-hop neighbour
//   <ray>_move          latched ray move arriving from that side
//   <hop>_move          latched knight move arriving from that hop
// Every output is registered with one cycle of latency.
module transceiver (
  input  logic        clk,
  input  logic        rst,
  input  logic        engineColor,
  input  logic [5:0]  pieceReg,
  input  logic [5:0]  posReg,
  input  logic [10:0] U_in,
  input  logic [10:0] D_in,
  input  logic [10:0] L_in,
  input  logic [10:0] R_in,
  input  logic [10:0] UL_in,
  input  logic [10:0] UR_in,
  input  logic [10:0] DL_in,
  input  logic [10:0] DR_in,
  input  logic [7:0]  UUL_in,
  input  logic [7:0]  UUR_in,
  input  logic [7:0]  LLU_in,
  input  logic [7:0]  RRU_in,
  input  logic [7:0]  DDL_in,
  input  logic [7:0]  DDR_in,
  input  logic [7:0]  LLD_in,
  input  logic [7:0]  RRD_in,
  output logic [10:0] U_out,
  output logic [10:0] D_out,
  output logic [10:0] L_out,
  output logic [10:0] R_out,
  output logic [10:0] UL_out,
  output logic [10:0] UR_out,
  output logic [10:0] DL_out,
  output logic [10:0] DR_out,
  output logic [7:0]  UUL_out,
  output logic [7:0]  UUR_out,
  output logic [7:0]  LLU_out,
  output logic [7:0]  RRU_out,
  output logic [7:0]  DDL_out,
  output logic [7:0]  DDR_out,
  output logic [7:0]  LLD_out,
  output logic [7:0]  RRD_out,
  output logic [10:0] U_move,
  output logic [10:0] D_move,
  output logic [10:0] L_move,
  output logic [10:0] R_move,
  output logic [10:0] UL_move,
  output logic [10:0] UR_move,
  output logic [10:0] DL_move,
  output logic [10:0] DR_move,
  output logic [7:0]  UUL_move,
  output logic [7:0]  UUR_move,
  output logic [7:0]  LLU_move,
  output logic [7:0]  RRU_move,
  output logic [7:0]  DDL_move,
  output logic [7:0]  DDR_move,
  output logic [7:0]  LLD_move,
  output logic [7:0]  RRD_move
);

  localparam int unsigned RAY_W = 11;
  localparam int unsigned KN_W  = 8;
  localparam int unsigned N_DIR = 8;

  // Ray index order pairs opposites as (2k, 2k+1): U D L R UL DR UR DL.
  // Orthogonals are 0..3; in the diagonals, even = upward, odd = downward.
  logic [RAY_W-1:0] w_ray_in   [N_DIR];
  logic [RAY_W-1:0] w_ray_out  [N_DIR];
  logic [RAY_W-1:0] w_ray_move [N_DIR];
  logic [KN_W-1:0]  w_kn_in    [N_DIR];
  logic [KN_W-1:0]  w_kn_out   [N_DIR];
  logic [KN_W-1:0]  w_kn_move  [N_DIR];

  logic [RAY_W-1:0] r_ray_out  [N_DIR];
  logic [RAY_W-1:0] r_ray_move [N_DIR];
  logic [KN_W-1:0]  r_kn_out   [N_DIR];
  logic [KN_W-1:0]  r_kn_move  [N_DIR];

  logic w_occupied;
  logic w_pc;
  logic w_opp_occ;
  logic w_can_land;

  assign w_ray_in[0] = U_in;   assign w_ray_in[1] = D_in;
  assign w_ray_in[2] = L_in;   assign w_ray_in[3] = R_in;
  assign w_ray_in[4] = UL_in;  assign w_ray_in[5] = DR_in;
  assign w_ray_in[6] = UR_in;  assign w_ray_in[7] = DL_in;

  assign w_kn_in[0] = UUL_in;  assign w_kn_in[1] = UUR_in;
  assign w_kn_in[2] = LLU_in;  assign w_kn_in[3] = RRU_in;
  assign w_kn_in[4] = DDL_in;  assign w_kn_in[5] = DDR_in;
  assign w_kn_in[6] = LLD_in;  assign w_kn_in[7] = RRD_in;

  assign w_occupied = (pieceReg[4:0] != 5'd0);
  assign w_pc       = pieceReg[5];
  assign w_opp_occ  = w_occupied && (w_pc != engineColor);
  assign w_can_land = !w_occupied || (w_pc != engineColor);

  // Orthogonal sides carry rook/king attacks, diagonal sides bishop/king/pawn.
  function automatic logic [RAY_W-1:0] f_filter(input logic i_orth,
                                                input logic [RAY_W-1:0] i_msg);
    logic [3:0] v_att;
    v_att = i_msg[9:6] & (i_orth ? 4'b1010 : 4'b0111);
    return (v_att != 4'd0) ? {i_msg[10], v_att, i_msg[5:0]} : RAY_W'(0);
  endfunction

  // Ray decode: own emission, pass-through of sliders, and move capture.
  always_comb begin
    logic [2:0]       v_d;
    logic             v_orth;
    logic [RAY_W-1:0] v_filt;
    logic [RAY_W-1:0] v_thru;
    logic [3:0]       v_own_att;
    logic [3:0]       v_fwd_att;
    logic [3:0]       v_mv_att;
    logic             v_pawn_fwd;
    w_ray_out  = '{default: '0};
    w_ray_move = '{default: '0};
    for (int unsigned d = 0; d < N_DIR; d++) begin
      v_d    = 3'(d);
      v_orth = (v_d < 3'd4);
      v_filt = f_filter(v_orth, w_ray_in[v_d]);
      v_thru = f_filter(v_orth, w_ray_in[v_d ^ 3'd1]);

      // Pawns capture forward: upward diagonals for white, downward for black.
      v_pawn_fwd = pieceReg[1] && !v_orth && (v_d[0] != w_pc);
      v_own_att  = v_orth ? {pieceReg[4], 1'b0, pieceReg[2], 1'b0}
                          : {1'b0, pieceReg[3], pieceReg[2], v_pawn_fwd};
      v_fwd_att  = {v_thru[9:8], 2'b00};

      if (w_occupied) begin
        w_ray_out[v_d] = (v_own_att != 4'd0) ? {w_pc, v_own_att, posReg} : RAY_W'(0);
      end else begin
        w_ray_out[v_d] = (v_fwd_att != 4'd0) ? {v_thru[10], v_fwd_att, v_thru[5:0]} : RAY_W'(0);
      end

      // A pawn attack only becomes a move when there is something to capture.
      v_mv_att = w_opp_occ ? v_filt[9:6] : {v_filt[9:7], 1'b0};
      if ((v_filt[10] == engineColor) && (v_mv_att != 4'd0) && w_can_land) begin
        w_ray_move[v_d] = {v_filt[10], v_mv_att, v_filt[5:0]};
      end
    end
  end

  // Knight decode: emit on all hops if holding a knight, latch landings.
  always_comb begin
    w_kn_out  = '{default: '0};
    w_kn_move = '{default: '0};
    for (int unsigned k = 0; k < N_DIR; k++) begin
      if (pieceReg[0]) begin
        w_kn_out[k] = {w_pc, 1'b1, posReg};
      end
      if (w_kn_in[k][6] && (w_kn_in[k][7] == engineColor) && w_can_land) begin
        w_kn_move[k] = w_kn_in[k];
      end
    end
  end

  // Single register stage for every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ray_out  <= '{default: '0};
      r_ray_move <= '{default: '0};
      r_kn_out   <= '{default: '0};
      r_kn_move  <= '{default: '0};
    end else begin
      r_ray_out  <= w_ray_out;
      r_ray_move <= w_ray_move;
      r_kn_out   <= w_kn_out;
      r_kn_move  <= w_kn_move;
    end
  end

  assign U_out  = r_ray_out[0];  assign D_out  = r_ray_out[1];
  assign L_out  = r_ray_out[2];  assign R_out  = r_ray_out[3];
  assign UL_out = r_ray_out[4];  assign DR_out = r_ray_out[5];
  assign UR_out = r_ray_out[6];  assign DL_out = r_ray_out[7];

  assign U_move  = r_ray_move[0];  assign D_move  = r_ray_move[1];
  assign L_move  = r_ray_move[2];  assign R_move  = r_ray_move[3];
  assign UL_move = r_ray_move[4];  assign DR_move = r_ray_move[5];
  assign UR_move = r_ray_move[6];  assign DL_move = r_ray_move[7];

  assign UUL_out = r_kn_out[0];  assign UUR_out = r_kn_out[1];
  assign LLU_out = r_kn_out[2];  assign RRU_out = r_kn_out[3];
  assign DDL_out = r_kn_out[4];  assign DDR_out = r_kn_out[5];
  assign LLD_out = r_kn_out[6];  assign RRD_out = r_kn_out[7];

  assign UUL_move = r_kn_move[0];  assign UUR_move = r_kn_move[1];
  assign LLU_move = r_kn_move[2];  assign RRU_move = r_kn_move[3];
  assign DDL_move = r_kn_move[4];  assign DDR_move = r_kn_move[5];
  assign LLD_move = r_kn_move[6];  assign RRD_move = r_kn_move[7];

endmodule

// File: tb/tb_transceiver.sv
// Bench for transceiver: a rule-level model predicts every output each cycle,
// and a set of hand-computed literals pins the key scenarios.
module tb_transceiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        eng;
  logic [5:0]  piece;
  logic [5:0]  pos;
  // Bench direction order: U D L R UL UR DL DR; hops UUL UUR LLU RRU DDL DDR LLD RRD.
  logic [10:0] ray_in  [8];
  logic [10:0] ray_out [8];
  logic [10:0] ray_mv  [8];
  logic [7:0]  kn_in   [8];
  logic [7:0]  kn_out  [8];
  logic [7:0]  kn_mv   [8];

  logic [10:0] e_ray_out [8];
  logic [10:0] e_ray_mv  [8];
  logic [7:0]  e_kn_out  [8];
  logic [7:0]  e_kn_mv   [8];
  bit          have_exp = 1'b0;

  int checks   = 0;
  int failures = 0;

  string RN[8] = '{"U", "D", "L", "R", "UL", "UR", "DL", "DR"};
  string KN[8] = '{"UUL", "UUR", "LLU", "RRU", "DDL", "DDR", "LLD", "RRD"};

  always #5 clk = ~clk;

  transceiver dut (
    .clk(clk), .rst(rst), .engineColor(eng), .pieceReg(piece), .posReg(pos),
    .U_in(ray_in[0]), .D_in(ray_in[1]), .L_in(ray_in[2]), .R_in(ray_in[3]),
    .UL_in(ray_in[4]), .UR_in(ray_in[5]), .DL_in(ray_in[6]), .DR_in(ray_in[7]),
    .UUL_in(kn_in[0]), .UUR_in(kn_in[1]), .LLU_in(kn_in[2]), .RRU_in(kn_in[3]),
    .DDL_in(kn_in[4]), .DDR_in(kn_in[5]), .LLD_in(kn_in[6]), .RRD_in(kn_in[7]),
    .U_out(ray_out[0]), .D_out(ray_out[1]), .L_out(ray_out[2]), .R_out(ray_out[3]),
    .UL_out(ray_out[4]), .UR_out(ray_out[5]), .DL_out(ray_out[6]), .DR_out(ray_out[7]),
    .UUL_out(kn_out[0]), .UUR_out(kn_out[1]), .LLU_out(kn_out[2]), .RRU_out(kn_out[3]),
    .DDL_out(kn_out[4]), .DDR_out(kn_out[5]), .LLD_out(kn_out[6]), .RRD_out(kn_out[7]),
    .U_move(ray_mv[0]), .D_move(ray_mv[1]), .L_move(ray_mv[2]), .R_move(ray_mv[3]),
    .UL_move(ray_mv[4]), .UR_move(ray_mv[5]), .DL_move(ray_mv[6]), .DR_move(ray_mv[7]),
    .UUL_move(kn_mv[0]), .UUR_move(kn_mv[1]), .LLU_move(kn_mv[2]), .RRU_move(kn_mv[3]),
    .DDL_move(kn_mv[4]), .DDR_move(kn_mv[5]), .LLD_move(kn_mv[6]), .RRD_move(kn_mv[7])
  );

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- rule-level model ----------------
  function automatic int opposite(input int d);
    case (d)
      0: return 1;  1: return 0;  2: return 3;  3: return 2;
      4: return 7;  5: return 6;  6: return 5;  default: return 4;
    endcase
  endfunction

  function automatic bit diag(input int d);
    return d >= 4;
  endfunction

  // What kinds of attack can arrive along side d.
  function automatic logic [10:0] accept(input int d, input logic [10:0] m);
    logic [3:0] a;
    a = m[9:6];
    if (diag(d)) a[3] = 1'b0;
    else begin a[2] = 1'b0; a[0] = 1'b0; end
    return (a == 4'd0) ? 11'd0 : {m[10], a, m[5:0]};
  endfunction

  task automatic model_eval();
    bit         occ;
    logic       c;
    logic [3:0] a;
    logic [10:0] f;
    occ = (piece[4:0] != 5'd0);
    c   = piece[5];
    for (int d = 0; d < 8; d++) begin
      if (occ) begin
        a[3] = piece[4] && !diag(d);
        a[2] = piece[3] && diag(d);
        a[1] = piece[2];
        a[0] = piece[1] && ((c && (d == 4 || d == 5)) || (!c && (d == 6 || d == 7)));
        e_ray_out[d] = (a == 4'd0) ? 11'd0 : {c, a, pos};
      end else begin
        f = accept(opposite(d), ray_in[opposite(d)]);
        a = {f[9:8], 2'b00};
        e_ray_out[d] = (a == 4'd0) ? 11'd0 : {f[10], a, f[5:0]};
      end
      f = accept(d, ray_in[d]);
      a = f[9:6];
      if (!occ || c == eng) a[0] = 1'b0;
      if (f == 11'd0 || f[10] != eng || (occ && c == eng) || a == 4'd0)
        e_ray_mv[d] = 11'd0;
      else
        e_ray_mv[d] = {f[10], a, f[5:0]};
      e_kn_out[d] = piece[0] ? {c, 1'b1, pos} : 8'd0;
      e_kn_mv[d]  = (kn_in[d][6] && kn_in[d][7] == eng && !(occ && c == eng)) ? kn_in[d] : 8'd0;
      if (rst) begin
        e_ray_out[d] = 11'd0; e_ray_mv[d] = 11'd0;
        e_kn_out[d]  = 8'd0;  e_kn_mv[d]  = 8'd0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_eval();
    have_exp = 1'b1;
  end

  // Outputs settle at posedge; compare them half a cycle later.
  always @(negedge clk) begin
    if (have_exp) begin
      for (int d = 0; d < 8; d++) begin
        chk({"out_", RN[d]}, ray_out[d], e_ray_out[d]);
        chk({"move_", RN[d]}, ray_mv[d], e_ray_mv[d]);
        chk({"out_", KN[d]}, 11'(kn_out[d]), 11'(e_kn_out[d]));
        chk({"move_", KN[d]}, 11'(kn_mv[d]), 11'(e_kn_mv[d]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_in();
    for (int d = 0; d < 8; d++) begin
      ray_in[d] = 11'd0;
      kn_in[d]  = 8'd0;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] plist [6] = '{6'b010000, 6'b001000, 6'b011000, 6'b000100, 6'b000010, 6'b000001};

  initial begin
    rst = 1'b1; eng = 1'b1; piece = 6'b111111; pos = 6'd63;
    for (int d = 0; d < 8; d++) begin
      ray_in[d] = 11'h7FF;
      kn_in[d]  = 8'hFF;
    end
    settle();
    chk("rst_U_out", ray_out[0], 11'd0);
    chk("rst_DR_move", ray_mv[7], 11'd0);
    chk("rst_RRD_out", 11'(kn_out[7]), 11'd0);
    chk("rst_UUR_move", 11'(kn_mv[1]), 11'd0);

    // Black queen on 28 with engine black: emits, never moves.
    @(negedge clk);
    rst = 1'b0; eng = 1'b0; piece = 6'b011000; pos = 6'd28;
    clear_in();
    ray_in[1] = 11'b0_1000_010100;
    ray_in[2] = 11'b0_1100_011101;
    ray_in[6] = 11'b0_0100_010011;
    kn_in[1]  = 8'b0_1_101011;
    for (int cyc = 0; cyc < 2; cyc++) begin
      settle();
      chk("queen_U_out", ray_out[0], 11'b0_1000_011100);
      chk("queen_R_out", ray_out[3], 11'b0_1000_011100);
      chk("queen_UL_out", ray_out[4], 11'b0_0100_011100);
      chk("queen_DR_out", ray_out[7], 11'b0_0100_011100);
      chk("queen_D_move", ray_mv[1], 11'd0);
      chk("queen_DL_move", ray_mv[6], 11'd0);
      chk("queen_UUR_move", 11'(kn_mv[1]), 11'd0);
      chk("queen_UUR_out", 11'(kn_out[1]), 11'd0);
    end

    // Empty square: rook ray passes through and is a move.
    @(negedge clk);
    piece = 6'b000000;
    clear_in();
    ray_in[1] = 11'b0_1000_010100;
    settle();
    chk("fwd_U_out", ray_out[0], 11'b0_1000_010100);
    chk("fwd_D_move", ray_mv[1], 11'b0_1000_010100);

    // King attack is a move but does not slide on.
    @(negedge clk);
    ray_in[1] = 11'b0_0010_010100;
    settle();
    chk("king_U_out", ray_out[0], 11'd0);
    chk("king_D_move", ray_mv[1], 11'b0_0010_010100);

    // White pawn occupant captured by black bishop+pawn attack.
    @(negedge clk);
    piece = 6'b100010;
    clear_in();
    ray_in[6] = 11'b0_0101_010011;
    settle();
    chk("wpawn_DL_move", ray_mv[6], 11'b0_0101_010011);
    chk("wpawn_U_out", ray_out[0], 11'd0);
    chk("wpawn_DL_out", ray_out[6], 11'd0);
    chk("wpawn_UL_out", ray_out[4], 11'b1_0001_011100);
    chk("wpawn_UR_out", ray_out[5], 11'b1_0001_011100);

    // Pawn attack into an empty square is not a move.
    @(negedge clk);
    piece = 6'b000000;
    ray_in[6] = 11'b0_0001_010011;
    settle();
    chk("epawn_DL_move", ray_mv[6], 11'd0);

    // Knight landing depends on engine colour.
    @(negedge clk);
    clear_in();
    kn_in[1] = 8'b1_1_101011;
    eng = 1'b1;
    settle();
    chk("kn_w_UUR_move", 11'(kn_mv[1]), 11'b1_1_101011);
    @(negedge clk);
    eng = 1'b0;
    settle();
    chk("kn_b_UUR_move", 11'(kn_mv[1]), 11'd0);

    // Opponent rook blocks an incoming white rook ray and is captured.
    @(negedge clk);
    eng = 1'b1; piece = 6'b010000; pos = 6'd9;
    clear_in();
    ray_in[0] = 11'b1_1010_000001;
    ray_in[4] = 11'b0_0100_000000;
    settle();
    chk("block_D_out", ray_out[1], 11'b0_1000_001001);
    chk("block_U_move", ray_mv[0], 11'b1_1010_000001);
    chk("block_UL_move", ray_mv[4], 11'd0);

    // Sweep piece types, colours and engine sides against the model.
    for (int p = 0; p < 6; p++) begin
      for (int cv = 0; cv < 2; cv++) begin
        for (int ev = 0; ev < 2; ev++) begin
          @(negedge clk);
          piece = {cv[0], plist[p][4:0]};
          eng   = ev[0];
          pos   = 6'(p * 11 + cv * 3 + ev);
          for (int d = 0; d < 8; d++) begin
            ray_in[d] = {d[0] ^ ev[0], 4'(d * 3 + p + 1), 6'(d + 40)};
            kn_in[d]  = {d[1] ^ cv[0], d[0] | ev[0], 6'(d + 8)};
          end
          settle();
        end
      end
    end

    // Empty square with every ray lit from both colours.
    @(negedge clk);
    piece = 6'b000000;
    for (int d = 0; d < 8; d++) ray_in[d] = {d[2], 4'b1111, 6'(d)};
    settle();
    @(negedge clk);
    rst = 1'b1;
    settle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
